// File: rtl/boot_loader_if.sv
// Byte-stream and instruction-memory write bus of the boot loader.
// master: byte source / observer side; slave: the loader itself.
interface boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_rstn;
  logic              boot_done;
  logic              boot_err;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_waddr, imem_wdata,
    input  cpu_rstn, boot_done, boot_err
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_waddr, imem_wdata,
    output cpu_rstn, boot_done, boot_err
  );
endinterface

// File: rtl/boot_loader.sv
// Boot loader: receives a framed program image over a byte stream
// (0xA5, LEN_HI, LEN_LO, 4*N big-endian data bytes [, checksum]), writes
// each word into instruction memory and releases the CPU reset when done.
// Optional feature macro: BOOT_LOADER_CSUM_EN adds a trailing XOR checksum
// byte that must match the XOR of all data bytes.
// All outputs are decoded from registered state or driven by registers.
module boot_loader #(
  parameter int ADDR_W = 10
) (
  input  logic         clk,
  input  logic         rst,
  boot_loader_if.slave bus
);

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int          IDX_W     = ADDR_W + 1;
  // Largest legal word count: the full memory capacity.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    SYNC,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
`ifdef BOOT_LOADER_CSUM_EN
    CSUM,
`endif
    RUN,
    ERROR
  } state_t;

  // Where the FSM goes once all words are written (or N = 0).
`ifdef BOOT_LOADER_CSUM_EN
  localparam state_t AFTER_DATA = CSUM;
`else
  localparam state_t AFTER_DATA = RUN;
`endif

  state_t            state_q;
  state_t            state_d;
  logic [15:0]       len_q;
  logic [IDX_W-1:0]  word_idx_q;
  logic [1:0]        byte_cnt_q;
  logic [31:0]       wdata_q;
`ifdef BOOT_LOADER_CSUM_EN
  logic [7:0]        csum_q;
`endif

  logic              accept;
  logic [15:0]       len_n;
  logic [16:0]       idx_next;
  logic              last_word;
  logic              rx_ready_c;
  logic              we_c;
  logic              run_c;
  logic              err_c;

  assign accept    = bus.rx_valid & rx_ready_c;
  assign len_n     = {len_q[15:8], bus.rx_data};
  assign idx_next  = 17'(word_idx_q) + 17'd1;
  assign last_word = (idx_next == {1'b0, len_q});

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SYNC;
    else     state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    rx_ready_c = 1'b0;
    we_c       = 1'b0;
    run_c      = 1'b0;
    err_c      = 1'b0;
    case (state_q)
      SYNC: begin
        rx_ready_c = 1'b1;
        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) state_d = LEN_HI;
      end
      LEN_HI: begin
        rx_ready_c = 1'b1;
        if (bus.rx_valid) state_d = LEN_LO;
      end
      LEN_LO: begin
        rx_ready_c = 1'b1;
        if (bus.rx_valid) begin
          if (len_n == 16'd0)                 state_d = AFTER_DATA;
          else if ({1'b0, len_n} > MAX_WORDS) state_d = ERROR;
          else                                state_d = DATA;
        end
      end
      DATA: begin
        rx_ready_c = 1'b1;
        if (bus.rx_valid && byte_cnt_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        we_c    = 1'b1;
        state_d = last_word ? AFTER_DATA : DATA;
      end
`ifdef BOOT_LOADER_CSUM_EN
      CSUM: begin
        rx_ready_c = 1'b1;
        if (bus.rx_valid) state_d = (bus.rx_data == csum_q) ? RUN : ERROR;
      end
`endif
      RUN: begin
        run_c = 1'b1;
      end
      ERROR: begin
        err_c = 1'b1;
      end
      default: begin
        state_d = SYNC;
      end
    endcase
  end

  // Length capture, word/byte counters, big-endian word assembly, checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      wdata_q    <= '0;
`ifdef BOOT_LOADER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      case (state_q)
        LEN_HI: if (accept) len_q[15:8] <= bus.rx_data;
        LEN_LO: if (accept) begin
          len_q[7:0] <= bus.rx_data;
          word_idx_q <= '0;
          byte_cnt_q <= '0;
`ifdef BOOT_LOADER_CSUM_EN
          csum_q     <= '0;
`endif
        end
        DATA: if (accept) begin
          wdata_q    <= {wdata_q[23:0], bus.rx_data};
          byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef BOOT_LOADER_CSUM_EN
          csum_q     <= csum_q ^ bus.rx_data;
`endif
        end
        WRITE: word_idx_q <= word_idx_q + IDX_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.rx_ready   = rx_ready_c;
  assign bus.imem_we    = we_c;
  assign bus.imem_waddr = word_idx_q[ADDR_W-1:0];
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_rstn   = run_c;
  assign bus.boot_done  = run_c;
  assign bus.boot_err   = err_c;

endmodule

// File: tb/tb_boot_loader.sv
// Testbench for boot_loader: table of frames plus hand-written reset abort.
// Expected memory writes are queued as frames are driven and checked as
// imem_we strobes appear.
`timescale 1ns/1ps
module tb_boot_loader;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  boot_loader_if #(.ADDR_W(ADDR_W)) bus ();
  boot_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit          junk;
    bit          hdr_only;
    bit          gap;
    bit          bad_csum;
    logic [15:0] len;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          exp_done;
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t  sb[$];
  int   errors   = 0;
  int   checks   = 0;
  int   wr_count = 0;
  vec_t vecs[6];
  int   n_vecs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit junk, bit hdr_only, bit gap, bit bad_csum,
                              logic [15:0] len, logic [31:0] w0, logic [31:0] w1,
                              bit exp_done, bit exp_err, int exp_writes);
    vec_t v;
    v.junk = junk; v.hdr_only = hdr_only; v.gap = gap; v.bad_csum = bad_csum;
    v.len = len; v.w0 = w0; v.w1 = w1;
    v.exp_done = exp_done; v.exp_err = exp_err; v.exp_writes = exp_writes;
    return v;
  endfunction

  function automatic logic [31:0] word_of(int i, logic [31:0] w0, logic [31:0] w1);
    if (i == 0) return w0;
    if (i == 1) return w1;
    return w0 ^ (32'(i) * 32'h9E3779B9);
  endfunction

  // Monitor: every write strobe is matched against the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (bus.boot_done || bus.boot_err)
        chk("done_err_exclusive", 32'(bus.boot_done & bus.boot_err), 32'd0);
      if (bus.imem_we) begin
        wr_count++;
        chk("rx_ready_in_write", 32'(bus.rx_ready), 32'd0);
        chk("strobe_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("waddr", 32'(bus.imem_waddr), 32'(e.addr));
          chk("wdata", bus.imem_wdata, e.data);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("rx_ready_timeout", 32'(n), 32'd0);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic send_frame(input vec_t v);
    logic [7:0]  cs;
    logic [31:0] w;
    wr_t         e;
    cs = 8'h00;
    if (v.junk) begin
      send_byte(8'h00, v.gap);
      send_byte(8'h13, v.gap);
    end
    send_byte(8'hA5, v.gap);
    send_byte(v.len[15:8], v.gap);
    send_byte(v.len[7:0], v.gap);
    if (!v.hdr_only) begin
      for (int i = 0; i < int'(v.len); i++) begin
        w = word_of(i, v.w0, v.w1);
        e.addr = ADDR_W'(i);
        e.data = w;
        sb.push_back(e);
        for (int b = 3; b >= 0; b--) begin
          send_byte(w[8*b +: 8], v.gap);
          cs = cs ^ w[8*b +: 8];
        end
      end
`ifdef BOOT_LOADER_CSUM_EN
      send_byte(v.bad_csum ? 8'h00 : cs, v.gap);
`endif
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_imem_we"},    32'(bus.imem_we),    32'd0);
    chk({tag, "_imem_waddr"}, 32'(bus.imem_waddr), 32'd0);
    chk({tag, "_imem_wdata"}, bus.imem_wdata,      32'd0);
    chk({tag, "_cpu_rstn"},   32'(bus.cpu_rstn),   32'd0);
    chk({tag, "_boot_done"},  32'(bus.boot_done),  32'd0);
    chk({tag, "_boot_err"},   32'(bus.boot_err),   32'd0);
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;
    sb.delete();
    wr_count = 0;
    @(negedge clk);
    chk("rx_ready_after_rst", 32'(bus.rx_ready), 32'd1);
  endtask

  task automatic wait_end_and_check(input vec_t v, input string tag);
    int n;
    n = 0;
    while (!(bus.boot_done || bus.boot_err) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (v.hdr_only) chk({tag, "_err_latency"}, 32'(n), 32'd0);
    repeat (2) @(negedge clk);
    chk({tag, "_boot_done"}, 32'(bus.boot_done), 32'(v.exp_done));
    chk({tag, "_boot_err"},  32'(bus.boot_err),  32'(v.exp_err));
    chk({tag, "_cpu_rstn"},  32'(bus.cpu_rstn),  32'(v.exp_done));
    chk({tag, "_rx_ready"},  32'(bus.rx_ready),  32'd0);
    chk({tag, "_writes"},    32'(wr_count),      32'(v.exp_writes));
    chk({tag, "_sb_empty"},  32'(sb.size()),     32'd0);
  endtask

  initial begin
    // junk,hdr_only,gap,bad_csum,len,w0,w1,done,err,writes
    vecs[0] = mk(1, 0, 0, 0, 16'h0001, 32'h20080005, 32'h0,        1, 0, 1);
    vecs[1] = mk(0, 0, 1, 0, 16'h0002, 32'h12345678, 32'h9ABCDEF0, 1, 0, 2);
    vecs[2] = mk(0, 0, 0, 0, 16'h0000, 32'h0,        32'h0,        1, 0, 0);
    vecs[3] = mk(0, 1, 0, 0, 16'h0401, 32'h0,        32'h0,        0, 1, 0);
    vecs[4] = mk(0, 0, 0, 0, 16'h0400, 32'hCAFEF00D, 32'h0BADBEEF, 1, 0, 1024);
    n_vecs = 5;
`ifdef BOOT_LOADER_CSUM_EN
    vecs[5] = mk(0, 0, 0, 1, 16'h0001, 32'h11223344, 32'h0,        0, 1, 1);
    n_vecs = 6;
`endif

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(negedge clk);

    for (int k = 0; k < n_vecs; k++) begin
      do_reset();
      send_frame(vecs[k]);
      wait_end_and_check(vecs[k], $sformatf("vec%0d", k));
    end

    // Reset in the middle of word 0, then a fresh frame must load normally.
    do_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    wr_count = 0;
    @(negedge clk);
    chk("abort_rx_ready", 32'(bus.rx_ready), 32'd1);
    send_frame(vecs[0]);
    wait_end_and_check(vecs[0], "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter ADDR_W, default 10, sets the instruction-memory word-address width (capacity 2^ADDR_W words).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 rx_valid  input  1  byte-stream source has a byte on rx_data.
REQ-005 rx_data  input  8  incoming byte.
REQ-006 rx_ready  output  1  loader can accept a byte; transfer occurs on a cycle with rx_valid&rx_ready.
REQ-007 imem_we  output  1  one-cycle instruction-memory write strobe.
REQ-008 imem_waddr  output  ADDR_W  word address of the write.
REQ-009 imem_wdata  output  32  instruction word to write.
REQ-010 cpu_rstn  output  1  active-low reset to the MIPS core; low until the image is loaded.
REQ-011 boot_done  output  1  image loaded successfully; sticky until rst.
REQ-012 boot_err  output  1  framing, length or checksum failure; sticky until rst.

Function
REQ-013 Frame format SHALL be: sync 0xA5, LEN_HI, LEN_LO (16-bit word count N), 4*N data bytes, then one checksum byte when BOOT_CSUM_EN is defined.
REQ-014 States SHALL be SYNC, LEN_HI, LEN_LO, DATA, WRITE, CSUM, RUN, ERROR.
REQ-015 In SYNC, any accepted byte other than 0xA5 SHALL be discarded and the state kept; 0xA5 moves to LEN_HI.
REQ-016 On LEN_LO acceptance: N=0 goes to CSUM (or RUN without BOOT_CSUM_EN); N>2^ADDR_W goes to ERROR; otherwise goes to DATA with word index 0 and byte count 0.
REQ-017 Data words SHALL be assembled big-endian: first byte of each group of 4 is imem_wdata[31:24].
REQ-018 On acceptance of the 4th byte of a word, the next cycle SHALL be WRITE: imem_we=1 for exactly one cycle, imem_waddr=word index, imem_wdata=assembled word.
REQ-019 rx_ready SHALL be 1 in SYNC, LEN_HI, LEN_LO, DATA, CSUM and 0 in WRITE, RUN, ERROR.
REQ-020 After WRITE the word index SHALL increment; if it equals N the state goes to CSUM (or RUN without BOOT_CSUM_EN), else back to DATA.
REQ-021 Word index SHALL never wrap; REQ-016 guarantees index < 2^ADDR_W at every write.
REQ-022 rx_valid low in any state SHALL stall the FSM with no state or counter change.
REQ-023 In RUN: cpu_rstn=1, boot_done=1, rx_ready=0, imem_we=0, held until rst.
REQ-024 In ERROR: cpu_rstn=0, boot_err=1, rx_ready=0, imem_we=0, held until rst.
REQ-025 boot_done and boot_err SHALL never be 1 simultaneously.
REQ-026 All outputs SHALL be registered or decoded from registered state only; no combinational path from rx_valid/rx_data to any output.

Reset
REQ-027 rst SHALL asynchronously force state SYNC, counters and checksum accumulator 0, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_rstn=0, boot_done=0, boot_err=0; rx_ready=1 from the first cycle after rst deasserts.
REQ-028 rst during any state, including mid-word, SHALL abort the load; words already written to instruction memory are not cleared.

Configuration
REQ-029 Macro BOOT_LOADER_CSUM_EN (referred to as BOOT_CSUM_EN above) when defined SHALL enable the CSUM state: the XOR of all 4*N data bytes is accumulated, and the trailing byte must equal it; match goes to RUN, mismatch goes to ERROR.
REQ-030 Without BOOT_LOADER_CSUM_EN, no checksum byte SHALL be expected, the CSUM state and accumulator SHALL be absent, and the transition after the last WRITE (or N=0) SHALL go directly to RUN.

Verification
REQ-031 Bytes 0x00,0x13,0xA5,0x00,0x01,0x20,0x08,0x00,0x05 (+0x2D with csum) -> single imem_we, waddr 0, wdata 0x20080005, then cpu_rstn=1, boot_done=1.
REQ-032 N=2, words 0x12345678, 0x9ABCDEF0, rx_valid toggling every other cycle -> two writes at waddr 0 and 1 with exact data, no extra strobes, rx_ready=0 during each WRITE cycle.
REQ-033 csum enabled: N=1, word 0x11223344, checksum byte 0x00 (correct is 0x44) -> no RUN, boot_err=1, cpu_rstn stays 0.
REQ-034 ADDR_W=10, LEN=0x0401 -> ERROR immediately after LEN_LO with zero imem_we pulses; LEN=0x0400 -> accepted.
REQ-035 rst pulsed after 2 data bytes of word 0 -> state SYNC, all outputs at reset values; a fresh valid frame then loads and reaches RUN normally.
REQ-036 N=0 frame (0xA5,0x00,0x00, +0x00 with csum) -> RUN with no imem_we pulse.
